// File: rtl/tlb_inv_seq.sv
// INVTLB sequencer: walks all TLB entries over the shared read port and clears E on matches.
// Optional INVTLB_HIT_CNT_EN adds inv_hit_cnt (entries cleared by the last walk).
module tlb_inv_seq #(
  parameter int LOG2TLBNUM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inv_start,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_vppn,
  input  logic [LOG2TLBNUM-1:0] wb_r_index,
  output logic [LOG2TLBNUM-1:0] tlb_r_index,
  input  logic                  tlb_r_e,
  input  logic                  tlb_r_g,
  input  logic [9:0]            tlb_r_asid,
  input  logic [18:0]           tlb_r_vppn,
  input  logic [5:0]            tlb_r_ps,
  output logic                  tlb_clr_we,
  output logic [LOG2TLBNUM-1:0] tlb_clr_index,
  output logic                  inv_busy,
  output logic                  inv_done,
`ifdef INVTLB_HIT_CNT_EN
  output logic [LOG2TLBNUM:0]   inv_hit_cnt,
`endif
  output logic                  inv_ine
);

  localparam logic [LOG2TLBNUM-1:0] LAST_IDX = {LOG2TLBNUM{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [LOG2TLBNUM-1:0] idx_q, idx_d;
  logic [4:0]            op_q;
  logic [9:0]            asid_q;
  logic [18:0]           vppn_q;
  logic                  clr_we_q, clr_we_d;
  logic [LOG2TLBNUM-1:0] clr_index_q;
  logic                  ine_q, ine_d;
  logic                  op_legal, accept;
  logic                  vmatch, amatch, op_match;

  assign op_legal = (inv_op <= 5'd6);
  assign accept   = (state_q == IDLE) && inv_start && op_legal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outside SCAN the read port belongs to WB (TLBRD).
  always_comb begin
    inv_busy    = (state_q != IDLE);
    inv_done    = (state_q == DONE);
    tlb_r_index = (state_q == SCAN) ? idx_q : wb_r_index;
  end

  // A 2 MB page (ps = 21) ignores the low 9 VPPN bits.
  always_comb begin
    vmatch = (tlb_r_ps == 6'd21) ? (tlb_r_vppn[18:9] == vppn_q[18:9])
                                 : (tlb_r_vppn == vppn_q);
    amatch = (tlb_r_asid == asid_q);
    case (op_q)
      5'd0, 5'd1: op_match = 1'b1;
      5'd2:       op_match = tlb_r_g;
      5'd3:       op_match = !tlb_r_g;
      5'd4:       op_match = !tlb_r_g && amatch;
      5'd5:       op_match = !tlb_r_g && amatch && vmatch;
      5'd6:       op_match = (tlb_r_g || amatch) && vmatch;
      default:    op_match = 1'b0;
    endcase
  end

  always_comb begin
    clr_we_d = (state_q == SCAN) && tlb_r_e && op_match;
    ine_d    = (state_q == IDLE) && inv_start && !op_legal;
    idx_d    = idx_q;
    if (accept) idx_d = '0;
    else if (state_q == SCAN && idx_q != LAST_IDX) idx_d = idx_q + LOG2TLBNUM'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      op_q        <= '0;
      asid_q      <= '0;
      vppn_q      <= '0;
      clr_we_q    <= 1'b0;
      clr_index_q <= '0;
      ine_q       <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      clr_we_q <= clr_we_d;
      ine_q    <= ine_d;
      if (accept) begin
        op_q   <= inv_op;
        asid_q <= inv_asid;
        vppn_q <= inv_vppn;
      end
      if (state_q == SCAN) clr_index_q <= idx_q;
    end
  end

  assign tlb_clr_we    = clr_we_q;
  assign tlb_clr_index = clr_index_q;
  assign inv_ine       = ine_q;

`ifdef INVTLB_HIT_CNT_EN
  // Counts alongside the registered clear so the total is final when inv_done rises.
  logic [LOG2TLBNUM:0] hit_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)         hit_cnt_q <= '0;
    else if (accept)   hit_cnt_q <= '0;
    else if (clr_we_d) hit_cnt_q <= hit_cnt_q + (LOG2TLBNUM+1)'(1);
  end

  assign inv_hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Randomized + directed bench for tlb_inv_seq against a timeline model of each walk.
module tb_tlb_inv_seq;
  localparam int N = 16;

  logic        clk, reset, inv_start;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [3:0]  wb_r_index, tlb_r_index, tlb_clr_index;
  logic        tlb_r_e, tlb_r_g, tlb_clr_we, inv_busy, inv_done, inv_ine;
  logic [9:0]  tlb_r_asid;
  logic [18:0] tlb_r_vppn;
  logic [5:0]  tlb_r_ps;
`ifdef INVTLB_HIT_CNT_EN
  logic [4:0]  inv_hit_cnt;
`endif

  int ent_e[N], ent_g[N], ent_asid[N], ent_vppn[N], ent_ps[N];

  assign tlb_r_e    = ent_e[tlb_r_index] != 0;
  assign tlb_r_g    = ent_g[tlb_r_index] != 0;
  assign tlb_r_asid = 10'(ent_asid[tlb_r_index]);
  assign tlb_r_vppn = 19'(ent_vppn[tlb_r_index]);
  assign tlb_r_ps   = 6'(ent_ps[tlb_r_index]);

  tlb_inv_seq #(.LOG2TLBNUM(4)) dut (
    .clk(clk), .reset(reset), .inv_start(inv_start), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vppn(inv_vppn), .wb_r_index(wb_r_index),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g),
    .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
    .tlb_clr_we(tlb_clr_we), .tlb_clr_index(tlb_clr_index),
    .inv_busy(inv_busy), .inv_done(inv_done),
`ifdef INVTLB_HIT_CNT_EN
    .inv_hit_cnt(inv_hit_cnt),
`endif
    .inv_ine(inv_ine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit rule_match(int op, int a, int v, int i);
    bit g  = ent_g[i] != 0;
    bit am = ent_asid[i] == a;
    bit vm = (ent_ps[i] == 21) ? ((ent_vppn[i] >> 9) == (v >> 9)) : (ent_vppn[i] == v);
    case (op)
      0, 1:    return 1'b1;
      2:       return g;
      3:       return !g;
      4:       return !g && am;
      5:       return !g && am && vm;
      6:       return (g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  // Model: a walk accepted at the end of cycle t0 has a fixed timeline relative to t0.
  int cyc = 0, t0 = 0, ine_cyc = -1;
  bit active = 0, chk_en = 0;
  bit hit[N];

  always @(posedge clk) begin
    if (reset) begin
      active  = 0;
      ine_cyc = -1;
    end else if (inv_start && !(active && cyc - t0 >= 1 && cyc - t0 <= N + 1)) begin
      if (inv_op <= 6) begin
        active = 1;
        t0     = cyc;
        for (int i = 0; i < N; i++)
          hit[i] = (ent_e[i] != 0) && rule_match(int'(inv_op), int'(inv_asid), int'(inv_vppn), i);
      end else begin
        ine_cyc = cyc + 1;
      end
    end
    cyc++;
    chk_en = 1;
  end

  int rel, e_ridx, e_cnt;
  bit e_busy, e_done, e_clr;

  always @(negedge clk) begin
    if (chk_en) begin
      rel    = cyc - t0;
      e_busy = active && rel >= 1 && rel <= N + 1;
      e_done = active && rel == N + 1;
      e_clr  = active && rel >= 2 && rel <= N + 1 && hit[(rel >= 2 && rel <= N + 1) ? rel - 2 : 0];
      e_ridx = (active && rel >= 1 && rel <= N) ? rel - 1 : int'(wb_r_index);
      chk("inv_busy", int'(inv_busy), int'(e_busy));
      chk("inv_done", int'(inv_done), int'(e_done));
      chk("inv_ine", int'(inv_ine), int'(cyc == ine_cyc));
      chk("tlb_clr_we", int'(tlb_clr_we), int'(e_clr));
      chk("tlb_r_index", int'(tlb_r_index), e_ridx);
      if (e_clr) chk("tlb_clr_index", int'(tlb_clr_index), rel - 2);
`ifdef INVTLB_HIT_CNT_EN
      e_cnt = 0;
      if (active && rel >= 1)
        for (int j = 0; j < N; j++) if (hit[j] && j + 2 <= rel) e_cnt++;
      if (!active || rel >= 1) chk("inv_hit_cnt", int'(inv_hit_cnt), e_cnt);
`endif
    end
  end

  // TLB side: apply clears and record them in order.
  int clr_q[$];
  bit saw_done = 0;
  always @(negedge clk) begin
    if (chk_en && tlb_clr_we === 1'b1) begin
      clr_q.push_back(int'(tlb_clr_index));
      ent_e[tlb_clr_index] = 0;
    end
    if (chk_en && inv_done === 1'b1) saw_done = 1;
  end

  bit rand_wb = 0;
  always @(posedge clk) begin
    #1;
    if (rand_wb) wb_r_index = 4'($urandom);
  end

  task automatic load_all(input int e, input int g, input int a, input int v, input int ps);
    for (int i = 0; i < N; i++) begin
      ent_e[i] = e; ent_g[i] = g; ent_asid[i] = a; ent_vppn[i] = v; ent_ps[i] = ps;
    end
  endtask

  task automatic pulse_start(input int op, input int a, input int v);
    clr_q.delete();
    saw_done = 0;
    inv_op = 5'(op); inv_asid = 10'(a); inv_vppn = 19'(v);
    inv_start = 1'b1;
    @(posedge clk); #1;
    inv_start = 1'b0;
  endtask

  task automatic run_walk(input int op, input int a, input int v, output int lat, output int busy_n);
    pulse_start(op, a, v);
    lat = -1;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (inv_busy) busy_n++;
      if (inv_done) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  int lat, busy_n, n2;
  int asids[2] = '{'h01A, 'h02B};
  int vppns[4] = '{'h12345, 'h12200, 'h00FFF, 'h12245};

  initial begin
    reset = 1'b1; inv_start = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0; wb_r_index = '0;
    load_all(1, 0, 0, 0, 12);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(inv_busy), 0);
    chk("rst_clr_we", int'(tlb_clr_we), 0);
    chk("rst_clr_index", int'(tlb_clr_index), 0);
    chk("rst_ine", int'(inv_ine), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // op 0 on a fully valid TLB: every index, in order, 17-cycle latency
    run_walk(0, 0, 0, lat, busy_n);
    chk("op0_latency", lat, 17);
    chk("op0_busy_cycles", busy_n, 17);
    chk("op0_clr_count", clr_q.size(), 16);
    for (int i = 0; i < clr_q.size(); i++) chk("op0_clr_order", clr_q[i], i);

    // op 2: only global entries 3 and 9
    load_all(1, 0, 5, 7, 12);
    ent_g[3] = 1; ent_g[9] = 1;
    run_walk(2, 0, 0, lat, busy_n);
    chk("op2_clr_count", clr_q.size(), 2);
    if (clr_q.size() == 2) begin
      chk("op2_first", clr_q[0], 3);
      chk("op2_second", clr_q[1], 9);
    end
`ifdef INVTLB_HIT_CNT_EN
    chk("op2_hit_cnt", int'(inv_hit_cnt), 2);
`endif

    // op 5: 4 KB exact match at 5, 2 MB coarse match at 6
    load_all(1, 0, 'h055, 'h12345, 12);
    ent_asid[5] = 'h01A; ent_vppn[5] = 'h12345; ent_ps[5] = 12;
    ent_asid[6] = 'h01A; ent_vppn[6] = 'h12200; ent_ps[6] = 21;
    run_walk(5, 'h01A, 'h12345, lat, busy_n);
    chk("op5_clr_count", clr_q.size(), 2);
    if (clr_q.size() == 2) begin
      chk("op5_first", clr_q[0], 5);
      chk("op5_second", clr_q[1], 6);
    end

    // illegal op: ine pulse only
    wb_r_index = 4'd5;
    load_all(1, 0, 0, 0, 12);
    pulse_start(7, 0, 0);
    @(negedge clk);
    chk("op7_ine", int'(inv_ine), 1);
    chk("op7_busy", int'(inv_busy), 0);
    chk("op7_r_index", int'(tlb_r_index), 5);
    repeat (20) @(posedge clk);
    #1;
    chk("op7_clr_count", clr_q.size(), 0);

    // reset while reading index 8
    load_all(1, 0, 0, 0, 12);
    pulse_start(0, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_r_index", int'(tlb_r_index), 8);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("rst_mid_clr_count", clr_q.size(), 8);
    chk("rst_mid_no_done", int'(saw_done), 0);
    load_all(1, 0, 0, 0, 12);
    run_walk(1, 0, 0, lat, busy_n);
    chk("after_rst_count", clr_q.size(), 16);
    if (clr_q.size() > 0) chk("after_rst_first", clr_q[0], 0);

    // op 3 with entry 2 invalid; WB owns the read port when idle
    load_all(1, 0, 0, 0, 12);
    ent_e[2] = 0;
    wb_r_index = 4'hB;
    run_walk(3, 0, 0, lat, busy_n);
    chk("op3_clr_count", clr_q.size(), 15);
    n2 = 0;
    foreach (clr_q[i]) if (clr_q[i] == 2) n2++;
    chk("op3_no_idx2", n2, 0);
    chk("idle_r_index", int'(tlb_r_index), 11);

    // randomized walks with stray starts while busy
    rand_wb = 1;
    for (int w = 0; w < 12; w++) begin
      for (int i = 0; i < N; i++) begin
        ent_e[i]    = ($urandom_range(0, 4) != 0) ? 1 : 0;
        ent_g[i]    = int'($urandom_range(0, 1));
        ent_asid[i] = asids[$urandom_range(0, 1)];
        ent_vppn[i] = vppns[$urandom_range(0, 3)];
        ent_ps[i]   = ($urandom_range(0, 1) != 0) ? 21 : 12;
      end
      pulse_start(int'($urandom_range(0, 7)), asids[$urandom_range(0, 1)], vppns[$urandom_range(0, 3)]);
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        inv_start = (k <= 15 && $urandom_range(0, 7) == 0);
        inv_op    = 5'($urandom);
      end
      inv_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    rand_wb = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
